// File: rtl/alu_seq_pkg.sv
// Shared opcodes, FSM states and the counter-width helper for alu_seq.
package alu_seq_pkg;

    localparam logic [2:0] OP_AND  = 3'b000;
    localparam logic [2:0] OP_OR   = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_MUL  = 3'b011;
    localparam logic [2:0] OP_ANDN = 3'b100;
    localparam logic [2:0] OP_ORN  = 3'b101;
    localparam logic [2:0] OP_SUB  = 3'b110;
    localparam logic [2:0] OP_SLT  = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

endpackage

// File: rtl/alu_mul_seq.sv
// Shift-add multiplier: one partial product per clock, low WIDTH bits kept.
module alu_mul_seq
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] product
);

    localparam int CW = clog2(WIDTH + 1);

    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [CW-1:0]    cnt;

    // product is the accumulator after the step taken at the coming edge
    assign product = acc + (mplier[0] ? mcand : '0);
    assign done    = busy & (cnt == CW'(1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy   <= 1'b0;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            cnt    <= '0;
        end else if (start) begin
            busy   <= 1'b1;
            acc    <= '0;
            mcand  <= a;
            mplier <= b;
            cnt    <= CW'(WIDTH);
        end else if (busy) begin
            acc    <= product;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt - CW'(1);
            busy   <= ~done;
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Registered ALU with valid/ready handshakes, flags and a multi-cycle multiply.
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter bit MUL_EN = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             carry,
    output logic             ovf
);

    state_t           state;
    logic             accept;
    logic             xfer;
    logic             mul_start;
    logic             mul_busy;
    logic             mul_done;
    logic [WIDTH-1:0] mul_product;

    logic             sub_op;
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH:0]   sum;
    logic             ov;
    logic             lt;
    logic [WIDTH-1:0] alu_res;
    logic             alu_c;
    logic             alu_v;

    assign in_ready = ~reset & ~mul_busy &
                      ((state == ST_IDLE) | ((state == ST_DONE) & out_ready));
    assign accept    = in_valid & in_ready;
    assign xfer      = out_valid & out_ready;
    assign mul_start = accept & (op == OP_MUL) & MUL_EN;

    alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .reset   (reset),
        .start   (mul_start),
        .a       (a),
        .b       (b),
        .busy    (mul_busy),
        .done    (mul_done),
        .product (mul_product)
    );

    // SUB and SLT share the adder as a + ~b + 1
    assign sub_op = (op == OP_SUB) | (op == OP_SLT);
    assign b_eff  = sub_op ? ~b : b;
    assign sum    = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, sub_op};
    assign ov     = (a[WIDTH-1] == b_eff[WIDTH-1]) & (sum[WIDTH-1] != a[WIDTH-1]);
    assign lt     = sum[WIDTH-1] ^ ov;

    always_comb begin
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        unique case (op)
            OP_AND:  alu_res = a & b;
            OP_OR:   alu_res = a | b;
            OP_ANDN: alu_res = a & ~b;
            OP_ORN:  alu_res = a | ~b;
            OP_MUL:  alu_res = '0;
            OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, lt};
            OP_ADD, OP_SUB: begin
                alu_res = sum[WIDTH-1:0];
                alu_c   = sum[WIDTH];
                alu_v   = ov;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            out_valid <= 1'b0;
            result    <= '0;
            zero      <= 1'b0;
            carry     <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE, ST_DONE: begin
                    if (accept) begin
                        if (mul_start) begin
                            state     <= ST_MUL;
                            out_valid <= 1'b0;
                        end else begin
                            state     <= ST_DONE;
                            out_valid <= 1'b1;
                            result    <= alu_res;
                            zero      <= (alu_res == '0);
                            carry     <= alu_c;
                            ovf       <= alu_v;
                        end
                    end else if (xfer) begin
                        state     <= ST_IDLE;
                        out_valid <= 1'b0;
                    end
                end
                ST_MUL: begin
                    if (mul_done) begin
                        state     <= ST_DONE;
                        out_valid <= 1'b1;
                        result    <= mul_product;
                        zero      <= (mul_product == '0);
                        carry     <= 1'b0;
                        ovf       <= 1'b0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: directed WIDTH=8 steps, exhaustive WIDTH=4 sweep.
module tb_alu_seq;

    logic       clk;
    logic       reset;

    logic       in_valid8, in_ready8, out_valid8, out_ready8;
    logic [7:0] a8, b8, result8;
    logic [2:0] op8;
    logic       zero8, carry8, ovf8;

    logic       in_valid4, in_ready4, out_valid4, out_ready4;
    logic [3:0] a4, b4, result4;
    logic [2:0] op4;
    logic       zero4, carry4, ovf4;

    int tests;
    int fails;

    logic [10:0] sb8[$];
    logic [6:0]  sb4[$];

    localparam logic [17:0] TOPS = {3'b010, 3'b110, 3'b000, 3'b001, 3'b111, 3'b101};

    alu_seq #(.WIDTH(8), .MUL_EN(1'b1)) dut8 (
        .clk(clk), .reset(reset),
        .in_valid(in_valid8), .in_ready(in_ready8),
        .a(a8), .b(b8), .op(op8),
        .out_valid(out_valid8), .out_ready(out_ready8),
        .result(result8), .zero(zero8), .carry(carry8), .ovf(ovf8)
    );

    alu_seq #(.WIDTH(4), .MUL_EN(1'b1)) dut4 (
        .clk(clk), .reset(reset),
        .in_valid(in_valid4), .in_ready(in_ready4),
        .a(a4), .b(b4), .op(op4),
        .out_valid(out_valid4), .out_ready(out_ready4),
        .result(result4), .zero(zero4), .carry(carry4), .ovf(ovf4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: {result[31:0], zero, carry, ovf} for a w-bit ALU
    function automatic logic [34:0] model(input int w, input logic [2:0] o,
                                          input logic [31:0] x, input logic [31:0] y);
        longint mask, ux, uy, sx, sy, full, s, smax, smin, r;
        logic c, v;
        mask = (longint'(1) << w) - 1;
        ux   = longint'(x) & mask;
        uy   = longint'(y) & mask;
        sx   = x[w-1] ? ux - (longint'(1) << w) : ux;
        sy   = y[w-1] ? uy - (longint'(1) << w) : uy;
        smax = (longint'(1) << (w - 1)) - 1;
        smin = -(longint'(1) << (w - 1));
        c = 1'b0;
        v = 1'b0;
        r = 0;
        case (o)
            3'b000: r = ux & uy;
            3'b001: r = ux | uy;
            3'b010: begin
                full = ux + uy;
                r = full & mask;
                c = full[w];
                s = sx + sy;
                v = (s > smax) || (s < smin);
            end
            3'b011: r = (ux * uy) & mask;
            3'b100: r = ux & ~uy & mask;
            3'b101: r = (ux | ~uy) & mask;
            3'b110: begin
                r = (ux - uy) & mask;
                c = (ux >= uy);
                s = sx - sy;
                v = (s > smax) || (s < smin);
            end
            default: r = (sx < sy) ? 1 : 0;
        endcase
        return {r[31:0], (r == 0), c, v};
    endfunction

    task automatic send8(input logic [2:0] o, input logic [7:0] x,
                         input logic [7:0] y, input logic [10:0] e);
        int n;
        n = 0;
        op8 = o;
        a8 = x;
        b8 = y;
        in_valid8 = 1'b1;
        while (!in_ready8 && n < 40) begin
            @(negedge clk);
            n++;
        end
        tests++;
        assert (in_ready8 === 1'b1) else begin
            fails++;
            $error("FAIL accept8: in_ready=%b required 1", in_ready8);
        end
        sb8.push_back(e);
        @(posedge clk);
        #1 in_valid8 = 1'b0;
    endtask

    task automatic expect8(input string tag, input int req_lat);
        int lat;
        bit ir_seen;
        logic [10:0] got, exp;
        lat = 0;
        ir_seen = 1'b0;
        forever begin
            @(negedge clk);
            if (out_valid8 || lat >= 40) break;
            if (in_ready8) ir_seen = 1'b1;
            lat++;
        end
        tests++;
        assert (lat === req_lat && !ir_seen) else begin
            fails++;
            $error("FAIL %s latency: got %0d (in_ready seen %b), required %0d", tag, lat, ir_seen, req_lat);
        end
        got = {result8, zero8, carry8, ovf8};
        exp = (sb8.size() > 0) ? sb8.pop_front() : 11'h7FF;
        tests++;
        assert (out_valid8 === 1'b1 && got === exp) else begin
            fails++;
            $error("FAIL %s: valid=%b got %h, required %h", tag, out_valid8, got, exp);
        end
    endtask

    initial begin
        logic [34:0] m;
        logic [7:0]  x, y;
        logic [2:0]  ot;
        logic [10:0] k;
        logic [6:0]  got4, exp4;
        int idx, got_n, cyc;

        tests = 0;
        fails = 0;
        reset = 1'b1;
        in_valid8 = 1'b0; out_ready8 = 1'b1; a8 = '0; b8 = '0; op8 = '0;
        in_valid4 = 1'b0; out_ready4 = 1'b1; a4 = '0; b4 = '0; op4 = '0;

        #12;
        tests++;
        assert ({out_valid8, result8, zero8, carry8, ovf8} === 12'h000) else begin
            fails++;
            $error("FAIL reset8: got %h, required 000", {out_valid8, result8, zero8, carry8, ovf8});
        end
        @(negedge clk) reset = 1'b0;
        @(negedge clk);
        tests++;
        assert (in_ready8 === 1'b1 && in_ready4 === 1'b1) else begin
            fails++;
            $error("FAIL ready_after_reset: got %b%b, required 11", in_ready8, in_ready4);
        end

        // Flags and overflow cases
        send8(3'b010, 8'h7F, 8'h01, {8'h80, 3'b001}); expect8("add_ovf", 0);
        send8(3'b110, 8'h05, 8'h05, {8'h00, 3'b110}); expect8("sub_eq", 0);
        send8(3'b110, 8'h00, 8'h01, {8'hFF, 3'b000}); expect8("sub_borrow", 0);
        send8(3'b111, 8'h80, 8'h01, {8'h01, 3'b000}); expect8("slt_neg", 0);
        send8(3'b111, 8'h7F, 8'h80, {8'h00, 3'b100}); expect8("slt_pos", 0);
        send8(3'b010, 8'hFF, 8'h01, {8'h00, 3'b110}); expect8("add_carry", 0);
        send8(3'b000, 8'hF0, 8'h3C, {8'h30, 3'b000}); expect8("and", 0);
        send8(3'b001, 8'hF0, 8'h0F, {8'hFF, 3'b000}); expect8("or", 0);
        send8(3'b100, 8'hF0, 8'h3C, {8'hC0, 3'b000}); expect8("andn", 0);
        send8(3'b101, 8'h00, 8'h0F, {8'hF0, 3'b000}); expect8("orn", 0);

        // Multiply: 8 idle cycles, in_ready low throughout
        send8(3'b011, 8'd13, 8'd11, {8'h8F, 3'b000}); expect8("mul_13x11", 8);
        send8(3'b011, 8'hFF, 8'd3, {8'hFD, 3'b000}); expect8("mul_m1x3", 8);

        // Back-to-back single-cycle ops at one per clock
        @(negedge clk);
        for (int i = 0; i <= 6; i++) begin
            if (i < 6) begin
                ot = TOPS[3*i +: 3];
                x = 8'($urandom);
                y = 8'($urandom);
                op8 = ot; a8 = x; b8 = y;
                in_valid8 = 1'b1;
                m = model(8, ot, {24'b0, x}, {24'b0, y});
                sb8.push_back({m[10:3], m[2:0]});
                tests++;
                assert (in_ready8 === 1'b1) else begin
                    fails++;
                    $error("FAIL tput_ready[%0d]: got %b, required 1", i, in_ready8);
                end
            end else begin
                in_valid8 = 1'b0;
            end
            if (i > 0) begin
                exp4 = '0;
                tests++;
                assert (out_valid8 === 1'b1 && {result8, zero8, carry8, ovf8} === sb8[0]) else begin
                    fails++;
                    $error("FAIL tput[%0d]: valid=%b got %h, required %h", i - 1, out_valid8,
                           {result8, zero8, carry8, ovf8}, sb8[0]);
                end
                void'(sb8.pop_front());
            end
            @(negedge clk);
        end

        // Backpressure holds result and blocks new input
        out_ready8 = 1'b0;
        send8(3'b010, 8'h05, 8'h03, {8'h08, 3'b000}); expect8("bp_add", 0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            tests++;
            assert ({out_valid8, result8, zero8, carry8, ovf8, in_ready8} === {1'b1, 8'h08, 3'b000, 1'b0}) else begin
                fails++;
                $error("FAIL bp_hold[%0d]: got %h, required %h", i,
                       {out_valid8, result8, zero8, carry8, ovf8, in_ready8}, {1'b1, 8'h08, 3'b000, 1'b0});
            end
        end
        out_ready8 = 1'b1;
        @(negedge clk);
        tests++;
        assert (out_valid8 === 1'b0) else begin
            fails++;
            $error("FAIL bp_release: out_valid=%b, required 0", out_valid8);
        end

        // Reset in the middle of a multiply clears outputs without a clock
        send8(3'b011, 8'd3, 8'd5, {8'h0F, 3'b000});
        repeat (3) @(negedge clk);
        tests++;
        assert (out_valid8 === 1'b0 && in_ready8 === 1'b0) else begin
            fails++;
            $error("FAIL mul_busy: valid=%b ready=%b, required 0 0", out_valid8, in_ready8);
        end
        #2 reset = 1'b1;
        #1;
        tests++;
        assert ({out_valid8, result8, zero8, carry8, ovf8} === 12'h000) else begin
            fails++;
            $error("FAIL reset_mid_mul: got %h, required 000", {out_valid8, result8, zero8, carry8, ovf8});
        end
        sb8.delete();
        @(negedge clk) reset = 1'b0;
        @(negedge clk);
        send8(3'b010, 8'h12, 8'h34, {8'h46, 3'b000}); expect8("after_reset", 0);

        // WIDTH=4: every opcode and operand pair, random backpressure
        idx = 0;
        got_n = 0;
        cyc = 0;
        while (got_n < 2048 && cyc < 50000) begin
            @(posedge clk);
            #1;
            out_ready4 = 1'($urandom_range(0, 1));
            if (idx < 2048) begin
                k = idx[10:0];
                op4 = k[10:8]; a4 = k[7:4]; b4 = k[3:0];
                in_valid4 = 1'b1;
            end else begin
                in_valid4 = 1'b0;
            end
            @(negedge clk);
            if (out_valid4 && out_ready4) begin
                got4 = {result4, zero4, carry4, ovf4};
                exp4 = (sb4.size() > 0) ? sb4.pop_front() : 7'h7F;
                tests++;
                assert (got4 === exp4) else begin
                    fails++;
                    $error("FAIL w4[%0d]: got %h, required %h", got_n, got4, exp4);
                end
                got_n++;
            end
            if (in_valid4 && in_ready4) begin
                m = model(4, op4, {28'b0, a4}, {28'b0, b4});
                sb4.push_back({m[6:3], m[2:0]});
                idx++;
            end
            cyc++;
        end
        in_valid4 = 1'b0;
        tests++;
        assert (got_n == 2048 && sb4.size() == 0) else begin
            fails++;
            $error("FAIL w4_count: got %0d results, required 2048", got_n);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
